// File: rtl/stable_match_pkg.sv
// Shared types and defaults for the round-robin propose scheduler.
// FSM state encoding plus default sizing constants.
package stable_match;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  localparam int LOGS_DEF    = 4;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_onehot_to_idx.sv
// One-hot to binary encoder built as a recursive halving OR-tree.
// Output is 0 when the one-hot input is 0.
module rr_onehot_to_idx #(
  parameter int logS = 4
) (
  input  logic [2**logS-1:0] oh,
  output logic [logS-1:0]    idx
);

  localparam int S = 2**logS;

  generate
    if (logS == 1) begin : g_leaf
      logic unused_lsb;
      assign unused_lsb = oh[0];
      assign idx = oh[1];
    end else begin : g_node
      logic [logS-2:0] lo_i;
      logic [logS-2:0] hi_i;

      rr_onehot_to_idx #(.logS(logS-1)) u_lo (
        .oh  (oh[S/2-1:0]),
        .idx (lo_i)
      );

      rr_onehot_to_idx #(.logS(logS-1)) u_hi (
        .oh  (oh[S-1:S/2]),
        .idx (hi_i)
      );

      assign idx = {|oh[S-1:S/2], lo_i | hi_i};
    end
  endgenerate

endmodule

// File: rtl/rr_propose_scheduler.sv
// Round-robin proposer scheduler: IDLE -> GRANT -> HOLD with sticky grants.
// Define PROPOSE_WATCHDOG_EN to build the HOLD watchdog (timeout pulse).
module rr_propose_scheduler
  import stable_match::*;
#(
  parameter int logS    = LOGS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**logS-1:0] req,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [2**logS-1:0] grant_onehot,
  output logic [logS-1:0]   grant_idx,
  input  logic              done,
  output logic              busy,
  output logic              timeout
);

  localparam int S = 2**logS;
  localparam logic [S-1:0] LSB = S'(1);

  state_t st, st_nx;
  logic [logS-1:0] ptr, ptr_nx;
  logic [S-1:0] oh, oh_nx;
  logic [S-1:0] ones, mask, hit, pick;

  // Two-pass find-first: bits at/above ptr, else wrap to lowest bit.
  assign ones = '1;
  assign mask = ones << ptr;
  assign hit  = req & mask;
  assign pick = (|hit) ? (hit & (~hit + LSB))
                       : (req & (~req + LSB));

`ifdef PROPOSE_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic tmo;
`endif

  always_comb begin
    st_nx  = st;
    ptr_nx = ptr;
    oh_nx  = oh;
`ifdef PROPOSE_WATCHDOG_EN
    cnt_nx = cnt;
    tmo    = 1'b0;
`endif
    unique case (st)
      IDLE: begin
        if (|req) begin
          oh_nx = pick;
          st_nx = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          st_nx  = HOLD;
          ptr_nx = grant_idx + logS'(1);
`ifdef PROPOSE_WATCHDOG_EN
          cnt_nx = '0;
`endif
        end
      end
      HOLD: begin
        if (done) begin
          st_nx = IDLE;
          oh_nx = '0;
        end
`ifdef PROPOSE_WATCHDOG_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo   = 1'b1;
          st_nx = IDLE;
          oh_nx = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`endif
      end
      default: begin
        st_nx = IDLE;
        oh_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      ptr <= '0;
      oh  <= '0;
    end else begin
      st  <= st_nx;
      ptr <= ptr_nx;
      oh  <= oh_nx;
    end
  end

`ifdef PROPOSE_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

  assign timeout = tmo;
`else
  assign timeout = 1'b0;
`endif

  rr_onehot_to_idx #(.logS(logS)) u_enc (
    .oh  (oh),
    .idx (grant_idx)
  );

  assign grant_onehot = oh;
  assign grant_valid  = (st == GRANT);
  assign busy         = (st != IDLE);

endmodule

// File: tb/tb_rr_propose_scheduler.sv
// Self-checking bench for rr_propose_scheduler: directed rounds with
// literal expectations plus randomized traffic against a reference model.
module tb_rr_propose_scheduler;

  localparam int LS = 4;
  localparam int S  = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [S-1:0] req = '0;
  logic grant_ready = 1'b0;
  logic done = 1'b0;
  logic grant_valid;
  logic [S-1:0] grant_onehot;
  logic [LS-1:0] grant_idx;
  logic busy;
  logic timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rr_propose_scheduler #(.logS(LS), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .done         (done),
    .busy         (busy),
    .timeout      (timeout)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 offering, 2 holding.
  int m_st = 0;
  int m_ptr = 0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_has = 0;
  bit m_f;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_has = 0;
    end else begin
      case (m_st)
        0: if (req != 0) begin
          m_f = 0;
          for (int k = 0; k < S; k++) begin
            if (!m_f && req[(m_ptr + k) % S]) begin
              m_idx = (m_ptr + k) % S;
              m_f = 1;
            end
          end
          m_has = 1;
          m_st = 1;
        end
        1: if (grant_ready) begin
          m_ptr = (m_idx + 1) % S;
          m_st = 2;
          m_cnt = 0;
        end
        default: begin
          if (done) begin
            m_st = 0;
            m_has = 0;
          end
`ifdef PROPOSE_WATCHDOG_EN
          else begin
            m_cnt++;
            if (m_cnt == TO) begin
              m_st = 0;
              m_has = 0;
            end
          end
`endif
        end
      endcase
    end
  end

  function automatic int exp_tmo();
`ifdef PROPOSE_WATCHDOG_EN
    return (m_st == 2 && m_cnt == TO - 1 && !done) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("valid", grant_valid, (m_st == 1) ? 1 : 0);
    chk("busy", busy, (m_st != 0) ? 1 : 0);
    chk("onehot", grant_onehot, m_has ? (1 << m_idx) : 0);
    chk("idx", grant_idx, m_has ? m_idx : 0);
    chk("timeout", timeout, exp_tmo());
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; grant_ready = 1'b0; done = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    while (!grant_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!grant_valid) chk("grant_wait", 0, 1);
  endtask

  task automatic round(input logic [S-1:0] r, input int dd,
                       output int idx, output int lat);
    req = r;
    grant_ready = 1'b1;
    wait_grant(lat);
    idx = grant_idx;
    tick();
    repeat (dd) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    int idx, lat, n;
    #1 rst = 1'b0;
    tick();
    chk("rst_valid", grant_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", grant_idx, 0);
    do_reset();

    // single requester re-granted every round, latency 1
    for (int i = 0; i < 3; i++) begin
      round(16'h0001, 1, idx, lat);
      chk("single_idx", idx, 0);
      chk("single_lat", lat, 1);
    end

    // full rotation with wrap
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      round(16'hFFFF, 0, idx, lat);
      chk("rot_idx", idx, k % 16);
    end

    // move ptr to 15, then wrap to 0
    round(16'h4000, 0, idx, lat);
    chk("p14", idx, 14);
    round(16'h8001, 0, idx, lat);
    chk("p15", idx, 15);
    round(16'h8001, 0, idx, lat);
    chk("p0", idx, 0);

    // sticky grant with ready low and req dropped
    req = 16'h0010;
    grant_ready = 1'b0;
    wait_grant(lat);
    chk("sticky_idx0", grant_idx, 4);
    req = '0;
    repeat (5) begin
      tick();
      chk("sticky_valid", grant_valid, 1);
      chk("sticky_idx", grant_idx, 4);
    end
    grant_ready = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    grant_ready = 1'b0;

    // done coinciding with acceptance is ignored
    req = 16'hFFFF;
    wait_grant(lat);
    chk("coinc_idx", grant_idx, 5);
    grant_ready = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    grant_ready = 1'b0;
    req = '0;
    repeat (3) begin
      chk("coinc_busy", busy, 1);
      chk("coinc_valid", grant_valid, 0);
      tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("coinc_idle", busy, 0);

    // asynchronous reset mid-HOLD
    req = 16'hFFFF;
    grant_ready = 1'b1;
    wait_grant(lat);
    tick();
    chk("hold_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", grant_valid, 0);
    chk("arst_oh", grant_onehot, 0);
    chk("arst_idx", grant_idx, 0);
    tick();
    rst = 1'b1;
    wait_grant(lat);
    chk("post_rst_idx", grant_idx, 0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;

    // HOLD without done
    req = 16'h0008;
    grant_ready = 1'b1;
    wait_grant(lat);
    chk("wd_idx", grant_idx, 3);
    tick();
    req = '0;
    grant_ready = 1'b0;
`ifdef PROPOSE_WATCHDOG_EN
    n = 1;
    while (!timeout && n < 30) begin
      tick();
      n++;
    end
    chk("wd_cycle", n, 8);
    tick();
    chk("wd_idle", busy, 0);
    chk("wd_pulse", timeout, 0);
    req = 16'hFFFF;
    wait_grant(lat);
    chk("wd_next", grant_idx, 4);
    grant_ready = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
`else
    n = 0;
    repeat (20) tick();
    chk("hold_wait", busy, 1);
    chk("no_tmo", timeout, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("hold_exit", busy, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom % 4)
        0: req = '0;
        1: req = S'(1) << ($urandom % S);
        2: req = S'($urandom);
        default: req = '1;
      endcase
      grant_ready = ($urandom % 3) != 0;
      done = ($urandom % 5) == 0;
      rst = ($urandom % 200) != 0;
      tick();
    end

    rst = 1'b1;
    req = '0;
    done = 1'b0;
    grant_ready = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_propose_scheduler.md
RR_PROPOSE_SCHEDULER -- requirements
Module: rr_propose_scheduler

Interface
REQ-001 SHALL have parameter logS, default 4, meaning log2 of requester count; S = 2**logS.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the HOLD watchdog limit in cycles (used only under REQ-027).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req, input, S, level requests, one bit per proposer.
REQ-006 SHALL have port grant_valid, output, 1, grant offered to the shared resource.
REQ-007 SHALL have port grant_ready, input, 1, the resource accepts the grant.
REQ-008 SHALL have port grant_onehot, output, S, the one-hot granted requester.
REQ-009 SHALL have port grant_idx, output, logS, the binary index of grant_onehot.
REQ-010 SHALL have port done, input, 1, a single-cycle pulse meaning the resource finished the current grant.
REQ-011 SHALL have port busy, output, 1, high in GRANT and HOLD.
REQ-012 SHALL have port timeout, output, 1, a single-cycle watchdog pulse (tied 0 without the macro).

Function
REQ-013 SHALL implement FSM states IDLE, GRANT and HOLD.
REQ-014 IDLE: when req != 0, SHALL select the first set bit at or above ptr, wrapping modulo S, register it into grant_onehot/grant_idx, and enter GRANT on the next edge, giving latency 1 from req to grant_valid.
REQ-015 IDLE with req == 0 SHALL stay in IDLE with grant_valid=0 and grant_onehot=0.
REQ-016 GRANT: grant_valid=1; grant_onehot and grant_idx SHALL be held stable until grant_valid && grant_ready.
REQ-017 GRANT SHALL be sticky: deasserting the granted req bit SHALL NOT withdraw the grant.
REQ-018 On acceptance the FSM SHALL enter HOLD, and ptr SHALL become (grant_idx+1) mod S, so index S-1 wraps to 0.
REQ-019 HOLD: grant_valid=0, grant_onehot/grant_idx retained; done SHALL return to IDLE on the next edge; a new grant needs at least one IDLE cycle.
REQ-020 done SHALL be ignored in IDLE and GRANT, including when it coincides with grant_ready.
REQ-021 grant_idx SHALL always equal the binary encoding of grant_onehot, and be 0 when grant_onehot == 0.
REQ-022 With a single requester active continuously, that requester SHALL be re-granted every round; with all bits set, grants SHALL rotate in order ptr, ptr+1, ...

Reset
REQ-023 While rst is low, the block SHALL be in state IDLE with ptr=0, grant_valid=0, grant_onehot=0, grant_idx=0, busy=0, timeout=0 and the watchdog counter at 0.
REQ-024 Reset SHALL take effect immediately, even mid-GRANT or mid-HOLD; any in-flight grant SHALL be discarded with no done required.
REQ-025 Deassertion SHALL be synchronised by the integrator; the block SHALL assume rst release is clean relative to clk.

Configuration
REQ-026 Macro PROPOSE_WATCHDOG_EN SHALL compile the HOLD watchdog in or out.
REQ-027 With the macro: a counter SHALL clear on HOLD entry and increment each HOLD cycle; on reaching TIMEOUT without done, the block SHALL pulse timeout for 1 cycle and return to IDLE; ptr SHALL keep its already-advanced value.
REQ-028 Without the macro: no counter SHALL exist, timeout SHALL be constant 0, and HOLD SHALL wait for done indefinitely.

Structure
REQ-029 The shared stable_match package SHALL hold the FSM state enum (IDLE/GRANT/HOLD) and the default logS/TIMEOUT constants.
REQ-030 One sub-module, rr_onehot_to_idx (parameter logS, recursive halving OR-tree one-hot to binary), SHALL derive grant_idx.
REQ-031 Priority masking (ptr mask, two-pass find-first) SHALL stay inside rr_propose_scheduler.

Verification
REQ-032 Reset then req=16'h0001, grant_ready=1, done pulsed 2 cycles after acceptance, repeated -> grant_idx=0 each round, grant_valid 1 cycle after req.
REQ-033 req=16'hFFFF, ready always 1, done 1 cycle after each accept -> grant_idx sequence 0,1,2,...,15,0 (wrap).
REQ-034 ptr=15 state, req=16'h8001 -> grant 15, then grant 0; req=16'h0010 with grant_ready held 0 for 5 cycles and req dropped -> grant_idx=4 stable, grant_valid held.
REQ-035 In GRANT, grant_ready and done high in the same cycle -> enters HOLD; done ignored; busy stays 1 until next done.
REQ-036 rst low mid-HOLD -> all outputs 0 immediately; first post-reset grant with req=16'hFFFF -> idx 0.
REQ-037 PROPOSE_WATCHDOG_EN, TIMEOUT=8, no done -> timeout pulses at 8th HOLD cycle, IDLE next, next grant = idx+1.
